// File: rtl/fp_mul_pkg.sv
// Shared encodings for the parametrised floating-point multiplier:
// FSM states, operand classes, rounding modes and flag bit positions.
package fp_mul_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLASS = 3'd1,
    S_MUL   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_PACK  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    C_ZERO = 2'd0,
    C_INF  = 2'd1,
    C_NAN  = 2'd2,
    C_NUM  = 2'd3
  } class_e;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam int FLAG_INV = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier. Subnormals report as ZERO (flushed);
// the sign bit is not needed here and is left to the caller.
module fp_classify
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] mag_i,
  output class_e                 cls_o,
  output logic                   snan_o
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] frac_f;

  assign exp_f  = mag_i[EXP_W+MAN_W-1:MAN_W];
  assign frac_f = mag_i[MAN_W-1:0];

  always_comb begin
    cls_o  = C_NUM;
    snan_o = 1'b0;
    if (exp_f == '0) begin
      cls_o = C_ZERO;
    end else if (&exp_f) begin
      if (frac_f == '0) begin
        cls_o = C_INF;
      end else begin
        cls_o  = C_NAN;
        snan_o = ~frac_f[MAN_W-1];
      end
    end
  end

endmodule

// File: rtl/fp_multiplier_param.sv
// Multi-cycle IEEE-754 multiplier, format set by EXP_W/MAN_W, four rounding
// modes, flush-to-zero, canonical qNaN and a start/done handshake.
module fp_multiplier_param
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ready,
  input  logic [1:0]             rnd_mode,
  input  logic [EXP_W+MAN_W:0]   op1,
  input  logic [EXP_W+MAN_W:0]   op2,
  output logic [EXP_W+MAN_W:0]   res,
  output logic [3:0]             flags,
  output logic                   busy,
  output logic                   done
);

  // state   | meaning
  // S_IDLE  | waiting for ready; captures operands and rounding mode
  // S_CLASS | classify operands, resolve NaN/Inf/zero results
  // S_MUL   | significand product and biased exponent sum
  // S_NORM  | one-bit normalise, split into fraction/guard/round/sticky
  // S_ROUND | apply rounding mode, propagate fraction carry
  // S_PACK  | range check and assemble result (special results pass through)
  // S_DONE  | res/flags valid, done high for this single cycle

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int PW   = 2*MAN_W + 2;
  localparam int XW   = EXP_W + 2;

  localparam logic [XW-1:0]    BIAS_X   = XW'(BIAS);
  localparam logic [XW-1:0]    ONE_X    = XW'(1);
  localparam logic [XW-1:0]    EXP_OVF  = XW'(2**EXP_W - 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

  state_e            state_q;
  logic [W-1:0]      op1_q, op2_q;
  logic [1:0]        rm_q;
  logic              sign_q;
  logic [XW-1:0]     exp_q;
  logic [PW-1:0]     prod_q;
  logic [MAN_W-1:0]  frac_q;
  logic              g_q, r_q, st_q, inx_q;
  logic              spec_q;
  logic [W-1:0]      spec_res_q;
  logic [3:0]        spec_flags_q;
  logic [W-1:0]      res_q;
  logic [3:0]        flags_q;
  logic              busy_q, done_q;

  logic              s1, s2;
  logic [EXP_W-1:0]  e1, e2;
  logic [MAN_W-1:0]  f1, f2;
  class_e            cls1, cls2;
  logic              snan1, snan2;

  assign s1 = op1_q[W-1];
  assign s2 = op2_q[W-1];
  assign e1 = op1_q[W-2:MAN_W];
  assign e2 = op2_q[W-2:MAN_W];
  assign f1 = op1_q[MAN_W-1:0];
  assign f2 = op2_q[MAN_W-1:0];

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (
    .mag_i  (op1_q[W-2:0]),
    .cls_o  (cls1),
    .snan_o (snan1)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls2 (
    .mag_i  (op2_q[W-2:0]),
    .cls_o  (cls2),
    .snan_o (snan2)
  );

  logic              spec_hit;
  logic [W-1:0]      spec_res;
  logic [3:0]        spec_flags;
  logic              zero_inf, any_nan;
  logic [PW-1:0]     prod_mul;
  logic [XW-1:0]     exp_mul;
  logic [PW-2:0]     prod_n;
  logic [XW-1:0]     exp_n;
  logic [MAN_W-1:0]  frac_n;
  logic              g_n, r_n, st_n;
  logic              inx_r, inc_r;
  logic [MAN_W:0]    frac_sum;
  logic [MAN_W-1:0]  frac_r;
  logic [XW-1:0]     exp_r;
  logic              unf_p, ovf_p;
  logic [W-1:0]      res_pk;
  logic [3:0]        flags_pk;

  always_comb begin
    // Special-operand resolution, in priority order NaN/0*Inf, Inf, zero.
    any_nan    = (cls1 == C_NAN) || (cls2 == C_NAN);
    zero_inf   = ((cls1 == C_ZERO) && (cls2 == C_INF)) ||
                 ((cls1 == C_INF) && (cls2 == C_ZERO));
    spec_hit   = 1'b0;
    spec_res   = '0;
    spec_flags = '0;
    if (any_nan || zero_inf) begin
      spec_hit             = 1'b1;
      spec_res             = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      spec_flags[FLAG_INV] = zero_inf | snan1 | snan2;
    end else if ((cls1 == C_INF) || (cls2 == C_INF)) begin
      spec_hit = 1'b1;
      spec_res = {s1 ^ s2, EXP_ONES, {MAN_W{1'b0}}};
    end else if ((cls1 == C_ZERO) || (cls2 == C_ZERO)) begin
      spec_hit = 1'b1;
      spec_res = {s1 ^ s2, {(W-1){1'b0}}};
    end

    prod_mul = PW'({1'b1, f1}) * PW'({1'b1, f2});
    exp_mul  = {2'b00, e1} + {2'b00, e2} - BIAS_X;

    prod_n = prod_q[PW-1] ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};
    exp_n  = prod_q[PW-1] ? exp_q + ONE_X : exp_q;
    frac_n = prod_n[PW-2 -: MAN_W];
    g_n    = prod_n[MAN_W];
    r_n    = prod_n[MAN_W-1];
    st_n   = |prod_n[MAN_W-2:0];

    inx_r = g_q | r_q | st_q;
    case (rm_q)
      RM_RNE:  inc_r = g_q & (r_q | st_q | frac_q[0]);
      RM_RUP:  inc_r = ~sign_q & inx_r;
      RM_RDN:  inc_r = sign_q & inx_r;
      default: inc_r = 1'b0;
    endcase
    frac_sum = {1'b0, frac_q} + {{MAN_W{1'b0}}, inc_r};
    frac_r   = frac_sum[MAN_W-1:0];
    exp_r    = frac_sum[MAN_W] ? exp_q + ONE_X : exp_q;

    unf_p    = exp_q[XW-1] || (exp_q == '0);
    ovf_p    = !exp_q[XW-1] && (exp_q >= EXP_OVF);
    res_pk   = {sign_q, exp_q[EXP_W-1:0], frac_q};
    flags_pk = {3'b000, inx_q};
    if (unf_p) begin
      res_pk             = {sign_q, {(W-1){1'b0}}};
      flags_pk           = '0;
      flags_pk[FLAG_UNF] = 1'b1;
      flags_pk[FLAG_INX] = 1'b1;
    end else if (ovf_p) begin
      flags_pk           = '0;
      flags_pk[FLAG_OVF] = 1'b1;
      flags_pk[FLAG_INX] = 1'b1;
      case (rm_q)
        RM_RTZ:  res_pk = {sign_q, EXP_MAXF, {MAN_W{1'b1}}};
        RM_RUP:  res_pk = sign_q ? {1'b1, EXP_MAXF, {MAN_W{1'b1}}}
                                 : {1'b0, EXP_ONES, {MAN_W{1'b0}}};
        RM_RDN:  res_pk = sign_q ? {1'b1, EXP_ONES, {MAN_W{1'b0}}}
                                 : {1'b0, EXP_MAXF, {MAN_W{1'b1}}};
        default: res_pk = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op1_q        <= '0;
      op2_q        <= '0;
      rm_q         <= RM_RNE;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      prod_q       <= '0;
      frac_q       <= '0;
      g_q          <= 1'b0;
      r_q          <= 1'b0;
      st_q         <= 1'b0;
      inx_q        <= 1'b0;
      spec_q       <= 1'b0;
      spec_res_q   <= '0;
      spec_flags_q <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (ready) begin
            op1_q   <= op1;
            op2_q   <= op2;
            rm_q    <= rnd_mode;
            flags_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CLASS;
          end
        end
        S_CLASS: begin
          sign_q       <= s1 ^ s2;
          spec_q       <= spec_hit;
          spec_res_q   <= spec_res;
          spec_flags_q <= spec_flags;
          // Special results take one pass through S_PACK: two-cycle latency.
          state_q      <= spec_hit ? S_PACK : S_MUL;
        end
        S_MUL: begin
          prod_q  <= prod_mul;
          exp_q   <= exp_mul;
          state_q <= S_NORM;
        end
        S_NORM: begin
          frac_q  <= frac_n;
          g_q     <= g_n;
          r_q     <= r_n;
          st_q    <= st_n;
          exp_q   <= exp_n;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          frac_q  <= frac_r;
          exp_q   <= exp_r;
          inx_q   <= inx_r;
          state_q <= S_PACK;
        end
        S_PACK: begin
          res_q   <= spec_q ? spec_res_q : res_pk;
          flags_q <= spec_q ? spec_flags_q : flags_pk;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign res   = res_q;
  assign flags = flags_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Randomised and directed bench for fp_multiplier_param (binary32 and half builds)
// against an exact integer reference model of the multiply-and-round rules.
module tb_fp_multiplier_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        sp_rst, sp_ready, sp_busy, sp_done;
  logic [1:0]  sp_rm;
  logic [31:0] sp_op1, sp_op2, sp_res;
  logic [3:0]  sp_flags;

  logic        hp_rst, hp_ready, hp_busy, hp_done;
  logic [1:0]  hp_rm;
  logic [15:0] hp_op1, hp_op2, hp_res;
  logic [3:0]  hp_flags;

  fp_multiplier_param #(.EXP_W(8), .MAN_W(23)) u_sp (
    .clk(clk), .rst(sp_rst), .ready(sp_ready), .rnd_mode(sp_rm),
    .op1(sp_op1), .op2(sp_op2), .res(sp_res), .flags(sp_flags),
    .busy(sp_busy), .done(sp_done)
  );

  fp_multiplier_param #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .rst(hp_rst), .ready(hp_ready), .rnd_mode(hp_rm),
    .op1(hp_op1), .op2(hp_op2), .res(hp_res), .flags(hp_flags),
    .busy(hp_busy), .done(hp_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact model: integer significand product, rounding judged on the discarded remainder.
  task automatic ref_mul(input int ew, input int mw, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] rm, output logic [63:0] r, output logic [3:0] fl,
                         output int lat);
    longint unsigned emax, mmask, ea, eb, fa, fb, p, q, rem, half, sgn, inf_v, maxf;
    int  bias, e, k;
    bit  sa, sb, s, za, zb, ia, ib, na, nb, sna, snb, inc, inx;
    emax  = (64'd1 << ew) - 64'd1;
    mmask = (64'd1 << mw) - 64'd1;
    bias  = (1 << (ew - 1)) - 1;
    sa = a[ew+mw];
    sb = b[ew+mw];
    ea = (a >> mw) & emax;
    eb = (b >> mw) & emax;
    fa = a & mmask;
    fb = b & mmask;
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == emax) && (fa == 0);
    ib = (eb == emax) && (fb == 0);
    na = (ea == emax) && (fa != 0);
    nb = (eb == emax) && (fb != 0);
    sna = na && (((fa >> (mw - 1)) & 64'd1) == 0);
    snb = nb && (((fb >> (mw - 1)) & 64'd1) == 0);
    s     = sa ^ sb;
    sgn   = s ? (64'd1 << (ew + mw)) : 64'd0;
    inf_v = sgn | (emax << mw);
    maxf  = sgn | ((emax - 64'd1) << mw) | mmask;
    r = 0; fl = 0; lat = 2;
    if (na || nb || (za && ib) || (ia && zb)) begin
      r     = (emax << mw) | (64'd1 << (mw - 1));
      fl[3] = (za && ib) || (ia && zb) || sna || snb;
    end else if (ia || ib) begin
      r = inf_v;
    end else if (za || zb) begin
      r = sgn;
    end else begin
      lat = 5;
      p = ((64'd1 << mw) | fa) * ((64'd1 << mw) | fb);
      e = int'(ea) + int'(eb) - bias;
      if (p >= (64'd1 << (2*mw + 1))) begin k = mw + 1; e++; end
      else k = mw;
      q    = p >> k;
      rem  = p & ((64'd1 << k) - 64'd1);
      half = 64'd1 << (k - 1);
      inx  = (rem != 0);
      case (rm)
        2'b00:   inc = (rem > half) || ((rem == half) && ((q & 64'd1) == 64'd1));
        2'b10:   inc = !s && inx;
        2'b11:   inc = s && inx;
        default: inc = 1'b0;
      endcase
      if (inc) q = q + 64'd1;
      if (q == (64'd1 << (mw + 1))) begin q = q >> 1; e++; end
      if (e <= 0) begin
        r = sgn; fl = 4'b0011;
      end else if (e >= int'(emax)) begin
        fl = 4'b0101;
        case (rm)
          2'b00:   r = inf_v;
          2'b01:   r = maxf;
          2'b10:   r = s ? maxf : inf_v;
          default: r = s ? inf_v : maxf;
        endcase
      end else begin
        r  = sgn | (longint'(e) << mw) | (q & mmask);
        fl = {3'b000, inx};
      end
    end
  endtask

  task automatic sp_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input bit poke, output logic [31:0] r, output logic [3:0] fl);
    logic [63:0] er;
    logic [3:0]  ef;
    int          el, lat;
    bit          busy_ok;
    ref_mul(8, 23, {32'b0, a}, {32'b0, b}, rm, er, ef, el);
    @(posedge clk); #1;
    chk("sp_idle", {62'b0, sp_busy, sp_done}, 64'd0);
    sp_op1 = a; sp_op2 = b; sp_rm = rm; sp_ready = 1'b1;
    @(posedge clk); #1;
    sp_ready = 1'b0; lat = 0; busy_ok = sp_busy;
    while (!sp_done && lat < 20) begin
      if (poke && lat == 1) begin
        sp_ready = 1'b1; sp_op1 = $urandom; sp_op2 = $urandom; sp_rm = 2'($urandom);
      end else sp_ready = 1'b0;
      @(posedge clk); #1;
      lat++;
      busy_ok = busy_ok && sp_busy;
    end
    sp_ready = 1'b0;
    r = sp_res; fl = sp_flags;
    chk("sp_latency", 64'(lat), 64'(el));
    chk("sp_busy", {63'b0, busy_ok}, 64'd1);
    chk("sp_res", {32'b0, r}, er);
    chk("sp_flags", {60'b0, fl}, {60'b0, ef});
  endtask

  task automatic hp_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                       input bit poke, output logic [15:0] r, output logic [3:0] fl);
    logic [63:0] er;
    logic [3:0]  ef;
    int          el, lat;
    bit          busy_ok;
    ref_mul(5, 10, {48'b0, a}, {48'b0, b}, rm, er, ef, el);
    @(posedge clk); #1;
    chk("hp_idle", {62'b0, hp_busy, hp_done}, 64'd0);
    hp_op1 = a; hp_op2 = b; hp_rm = rm; hp_ready = 1'b1;
    @(posedge clk); #1;
    hp_ready = 1'b0; lat = 0; busy_ok = hp_busy;
    while (!hp_done && lat < 20) begin
      if (poke && lat == 1) begin
        hp_ready = 1'b1; hp_op1 = 16'($urandom); hp_op2 = 16'($urandom); hp_rm = 2'($urandom);
      end else hp_ready = 1'b0;
      @(posedge clk); #1;
      lat++;
      busy_ok = busy_ok && hp_busy;
    end
    hp_ready = 1'b0;
    r = hp_res; fl = hp_flags;
    chk("hp_latency", 64'(lat), 64'(el));
    chk("hp_busy", {63'b0, busy_ok}, 64'd1);
    chk("hp_res", {48'b0, r}, er);
    chk("hp_flags", {60'b0, fl}, {60'b0, ef});
  endtask

  function automatic logic [31:0] rnd_sp();
    logic [31:0] v;
    int sel;
    v   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 6)       v[30:23] = 8'($urandom_range(100, 154));
    else if (sel == 6) v[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
    else if (sel == 7) v[30:0]  = {8'hFF, 23'h0};
    else if (sel == 8) v[30:23] = 8'($urandom_range(190, 254));
    return v;
  endfunction

  function automatic logic [15:0] rnd_hp();
    logic [15:0] v;
    int sel;
    v   = 16'($urandom);
    sel = $urandom_range(0, 9);
    if (sel < 6)       v[14:10] = 5'($urandom_range(10, 20));
    else if (sel == 6) v[14:10] = ($urandom_range(0, 1) != 0) ? 5'h1F : 5'h00;
    else if (sel == 7) v[14:10] = 5'($urandom_range(22, 30));
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [15:0] hr;
    logic [3:0]  f;
    bit          seen;
    sp_rst = 1'b1; hp_rst = 1'b1;
    sp_ready = 1'b0; hp_ready = 1'b0;
    sp_rm = 2'b00; hp_rm = 2'b00;
    sp_op1 = '0; sp_op2 = '0; hp_op1 = '0; hp_op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    sp_rst = 1'b0; hp_rst = 1'b0;
    chk("rst_sp_res", {32'b0, sp_res}, 64'd0);
    chk("rst_sp_flags", {60'b0, sp_flags}, 64'd0);
    chk("rst_sp_busy_done", {62'b0, sp_busy, sp_done}, 64'd0);
    chk("rst_hp_res", {48'b0, hp_res}, 64'd0);

    sp_op(32'h40400000, 32'h40200000, 2'b00, 1'b1, r, f);
    chk("t1_res", {32'b0, r}, 64'h40F00000);
    chk("t1_flags", {60'b0, f}, 64'd0);
    sp_op(32'h00000000, 32'h7F800000, 2'b00, 1'b0, r, f);
    chk("t2a_res", {32'b0, r}, 64'h7FC00000);
    chk("t2a_flags", {60'b0, f}, 64'h8);
    sp_op(32'h7FA00000, 32'h3F800000, 2'b00, 1'b1, r, f);
    chk("t2b_res", {32'b0, r}, 64'h7FC00000);
    chk("t2b_flags", {60'b0, f}, 64'h8);
    sp_op(32'h7F7FFFFF, 32'h40000000, 2'b00, 1'b0, r, f);
    chk("t3_rne_res", {32'b0, r}, 64'h7F800000);
    chk("t3_rne_flags", {60'b0, f}, 64'h5);
    sp_op(32'h7F7FFFFF, 32'h40000000, 2'b01, 1'b0, r, f);
    chk("t3_rtz_res", {32'b0, r}, 64'h7F7FFFFF);
    chk("t3_rtz_flags", {60'b0, f}, 64'h5);
    sp_op(32'h80800000, 32'h3F000000, 2'b00, 1'b0, r, f);
    chk("t4_res", {32'b0, r}, 64'h80000000);
    chk("t4_flags", {60'b0, f}, 64'h3);
    sp_op(32'h3FC00000, 32'h3F800001, 2'b00, 1'b0, r, f);
    chk("t5_rne_res", {32'b0, r}, 64'h3FC00002);
    sp_op(32'h3FC00000, 32'h3F800001, 2'b01, 1'b0, r, f);
    chk("t5_rtz_res", {32'b0, r}, 64'h3FC00001);
    sp_op(32'h3F800001, 32'h3F800001, 2'b10, 1'b0, r, f);
    chk("t5_rup_res", {32'b0, r}, 64'h3F800003);
    sp_op(32'h3F800001, 32'h3F800001, 2'b11, 1'b0, r, f);
    chk("t5_rdn_res", {32'b0, r}, 64'h3F800002);
    chk("t5_flags", {60'b0, f}, 64'h1);

    for (int i = 0; i < 300; i++)
      sp_op(rnd_sp(), rnd_sp(), 2'($urandom), ($urandom_range(0, 3) == 0), r, f);

    hp_op(16'h4000, 16'h4200, 2'b00, 1'b1, hr, f);
    chk("t6_res", {48'b0, hr}, 64'h4600);
    chk("t6_flags", {60'b0, f}, 64'd0);

    // Abort: reset lands while the half-precision unit sits in S_ROUND.
    @(posedge clk); #1;
    hp_op1 = 16'h4000; hp_op2 = 16'h4200; hp_rm = 2'b00; hp_ready = 1'b1;
    @(posedge clk); #1;
    hp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    hp_rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_res", {48'b0, hp_res}, 64'd0);
    chk("abort_flags", {60'b0, hp_flags}, 64'd0);
    chk("abort_busy_done", {62'b0, hp_busy, hp_done}, 64'd0);
    hp_rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (hp_done) seen = 1'b1;
    end
    chk("abort_no_done", {63'b0, seen}, 64'd0);

    for (int i = 0; i < 60; i++)
      hp_op(rnd_hp(), rnd_hp(), 2'($urandom), ($urandom_range(0, 3) == 0), hr, f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
